sevenseg_mux: RTL and testbench
===============================

// Module: sevenseg_mux
// PURPOSE
//  Time-multiplexed driver for an NUM_DIGITS-digit common seven-segment display.
//  Sits directly upstream of the per-digit seven-segment decoder: out_digit feeds its
//  in_digit nibble input, out_sel drives the digit-enable lines of the display.
//  Scans one digit per refresh tick, using a tear-free shadow copy of the value.
// PARAMETERS
//  NUM_DIGITS      4           number of display digits (1..8)
//  MAIN_CLK        50_000_000  in_clk frequency [Hz]
//  DIGIT_CLK       1_000       per-digit refresh rate [Hz]; DIV = MAIN_CLK/DIGIT_CLK, clamped to >= 2
//  SEL_ZERO_IS_ON  0           1: out_sel active-low, 0: out_sel active-high
// PORTS
//  in_clk     in   1               system clock
//  in_rst     in   1               asynchronous reset, active-high
//  in_value   in   4*NUM_DIGITS    hex value; nibble i = digit i, digit 0 = least significant
//  in_update  in   1               1-cycle strobe: capture in_value into the pending register
//  out_digit  out  4               nibble of the currently selected digit
//  out_sel    out  NUM_DIGITS      one-hot digit enable (polarity per SEL_ZERO_IS_ON)
//  out_idx    out  3               index of the currently selected digit
//  out_blank  out  1               1: current digit must be dark (segments off)
//  out_frame  out  1               1-cycle pulse when scanning wraps back to digit 0
// BEHAVIOUR
//  - Reset (async, immediate): prescaler=0, idx=0, shadow=0, pending=0, pend_flag=0,
//    out_digit=0, out_idx=0, out_sel = digit 0 active, out_blank=0, out_frame=0.
//  - Prescaler counts 0..DIV-1. At count DIV-1 it wraps to 0 (tick); on tick, idx advances
//    by 1 and wraps NUM_DIGITS-1 -> 0. NUM_DIGITS=1: idx stays 0, out_frame pulses every tick.
//  - All outputs are registered and change on the same edge as idx. out_digit = shadow
//    nibble[idx]. out_sel has exactly one active bit, at position idx.
//  - in_update=1: pending <= in_value, pend_flag <= 1. A later strobe overwrites pending.
//  - Shadow load: on the tick where idx wraps to 0, if pend_flag, shadow <= pending and
//    pend_flag <= 0. The new digit-0 output already uses the new value, so a frame never
//    mixes old and new digits.
//  - If in_update coincides with the wrap tick, the value being strobed (in_value) is loaded
//    directly into shadow for the frame now starting, and pend_flag ends at 0.
//  - out_frame = 1 for exactly the cycle after the wrap edge, i.e. while idx=0 is first shown.
//  - in_update held high: pending tracks in_value every cycle; no other effect.
//  - Reset mid-frame discards pending and shadow; after release, scanning restarts at digit 0.
//  - Width rules: prescaler width = $clog2(DIV); idx is 3 bits; bits of out_idx beyond
//    $clog2(NUM_DIGITS) read 0.
// CONFIGURATION
//  SEVENSEG_MUX_BLANK_EN defined: leading-zero blanking. When shadow loads, a blank mask
//    register is computed. Digit i is blanked if i>0 and every nibble j>=i is 0. Digit 0 is
//    never blanked, so value 0 shows "0". For a blanked digit, out_blank=1 and out_sel is
//    fully inactive. Otherwise out_blank=0.
//  SEVENSEG_MUX_BLANK_EN undefined: mask logic absent, out_blank tied to 0, and every digit
//    is always driven.
// TESTING  (bench: NUM_DIGITS=4, MAIN_CLK=8, DIGIT_CLK=2 -> DIV=4)
//  1 reset, no strobe -> out_sel=4'b0001, out_digit=0; out_sel becomes 0010, 0100, 1000,
//    0001 at cycles 4, 8, 12, 16; out_frame pulses once every 16 cycles.
//  2 in_value=16'h12AB, strobe mid-frame -> digits unchanged until wrap; the next frame
//    shows B, A, 2, 1 for idx 0..3, with out_digit stable for 4 cycles each.
//  3 strobe 16'h1111 then 16'h2222 in the same frame -> next frame shows only 2s; 1s never
//    appear. Repeat with the strobe on the exact wrap cycle -> that frame shows the new
//    value from digit 0.
//  4 assert in_rst at idx=2 with a strobe pending -> outputs go to reset values at once;
//    after release, the pending value is gone and the display shows 0000.
//  5 BLANK_EN, value 16'h0050 -> out_blank=1 at idx 2,3 with out_sel=0000 there; value
//    16'h0000 -> only idx 0 lit, showing 0. Without the macro, out_blank stays 0 throughout.
//  6 SEL_ZERO_IS_ON=1 -> at idx=1, out_sel=4'b1101; reset value is 4'b1110.

Source files
------------

// File: rtl/sevenseg_mux.sv
// -----------------------------------------------------------------------------
// sevenseg_mux
//   Time-multiplexed scanner for a NUM_DIGITS-digit seven-segment display.
//   One digit is shown per refresh tick. Frames are tear-free: a new value is
//   first held in a pending register. It is copied into the shadow register that
//   the scanner reads only when scanning wraps back to digit 0.
//
// Parameters
//   NUM_DIGITS      number of digits (1..8)
//   MAIN_CLK        in_clk frequency [Hz]
//   DIGIT_CLK       per-digit refresh rate [Hz]; divider = MAIN_CLK/DIGIT_CLK (min 2)
//   SEL_ZERO_IS_ON  1: out_sel active-low, 0: out_sel active-high
//
// Ports
//   in_clk     system clock
//   in_rst     asynchronous reset, active-high
//   in_value   hex value, nibble i = digit i (digit 0 least significant)
//   in_update  1-cycle strobe, captures in_value into the pending register
//   out_digit  nibble of the currently selected digit
//   out_sel    one-hot digit enable (polarity from SEL_ZERO_IS_ON)
//   out_idx    index of the currently selected digit
//   out_blank  1: current digit must be dark
//   out_frame  1-cycle pulse while digit 0 of a new frame is first shown
//
// Build option
//   SEVENSEG_MUX_BLANK_EN  when defined, enables leading-zero blanking. A blank
//                          mask is computed each time the shadow register loads.
//                          A blanked digit drives out_blank=1 and leaves every
//                          out_sel line inactive. When undefined, out_blank is
//                          tied to 0.
// -----------------------------------------------------------------------------
module sevenseg_mux #(
    parameter int NUM_DIGITS     = 4,
    parameter int MAIN_CLK       = 50_000_000,
    parameter int DIGIT_CLK      = 1_000,
    parameter int SEL_ZERO_IS_ON = 0
) (
    input  logic                      in_clk,
    input  logic                      in_rst,
    input  logic [4*NUM_DIGITS-1:0]   in_value,
    input  logic                      in_update,
    output logic [3:0]                out_digit,
    output logic [NUM_DIGITS-1:0]     out_sel,
    output logic [2:0]                out_idx,
    output logic                      out_blank,
    output logic                      out_frame
);

    localparam int DIV_RAW = MAIN_CLK / DIGIT_CLK;
    localparam int DIV     = (DIV_RAW < 2) ? 2 : DIV_RAW;
    localparam int PW      = $clog2(DIV);
    localparam int W       = 4 * NUM_DIGITS;

    localparam logic [PW-1:0]         PRE_LAST = PW'(DIV - 1);
    localparam logic [2:0]            IDX_LAST = 3'(NUM_DIGITS - 1);
    localparam logic                  SEL_POL  = (SEL_ZERO_IS_ON != 0);
    localparam logic [NUM_DIGITS-1:0] SEL_INV  = {NUM_DIGITS{SEL_POL}};
    localparam logic [NUM_DIGITS-1:0] SEL_RST  = NUM_DIGITS'(1) ^ SEL_INV;

    logic [PW-1:0]          presc_reg, presc_next;
    logic [2:0]             idx_reg, idx_next;
    logic [W-1:0]           shadow_reg, shadow_next;
    logic [W-1:0]           pending_reg, pending_next;
    logic                   pend_flag_reg, pend_flag_next;
    logic [3:0]             digit_reg, digit_next;
    logic [NUM_DIGITS-1:0]  sel_reg, sel_next;
    logic [NUM_DIGITS-1:0]  onehot_next;
    logic                   frame_reg;
    logic                   tick, wrap;

    // Prescaler, scan index and the pending/shadow handoff
    always_comb begin
        tick           = (presc_reg == PRE_LAST);
        wrap           = tick && (idx_reg == IDX_LAST);
        presc_next     = tick ? '0 : presc_reg + PW'(1);
        idx_next       = idx_reg;
        pending_next   = pending_reg;
        pend_flag_next = pend_flag_reg;
        shadow_next    = shadow_reg;

        if (tick) begin
            idx_next = (idx_reg == IDX_LAST) ? 3'd0 : idx_reg + 3'd1;
        end

        if (in_update) begin
            pending_next   = in_value;
            pend_flag_next = 1'b1;
        end

        // At the frame boundary a strobe arriving in the same cycle wins.
        // It goes straight into the shadow, so the new frame starts with it.
        if (wrap) begin
            if (in_update) begin
                shadow_next    = in_value;
                pend_flag_next = 1'b0;
            end else if (pend_flag_reg) begin
                shadow_next    = pending_reg;
                pend_flag_next = 1'b0;
            end
        end
    end

    // Outputs are computed from the next-state values, so they change on the
    // same edge as the scan index.
    always_comb begin
        digit_next = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_next == 3'(i)) begin
                digit_next = shadow_next[4*i +: 4];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_onehot
            assign onehot_next[gi] = (idx_next == 3'(gi));
        end
    endgenerate

`ifdef SEVENSEG_MUX_BLANK_EN
    logic [NUM_DIGITS-1:0]  mask_calc, mask_reg, mask_next;
    logic                   blank_reg, blank_next;
    logic                   load;

    // The shadow register takes a new value exactly when this is true
    assign load = wrap && (in_update || pend_flag_reg);

    // Digit i is a leading zero when it and every higher nibble are zero.
    // Digit 0 stays lit so a zero value still reads "0".
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_mask
            if (gi == 0) begin : g_first
                assign mask_calc[gi] = 1'b0;
            end else begin : g_rest
                assign mask_calc[gi] = (shadow_next[W-1:4*gi] == '0);
            end
        end
    endgenerate

    assign mask_next  = load ? mask_calc : mask_reg;
    assign blank_next = |(mask_next & onehot_next);
    assign sel_next   = blank_next ? '0 : onehot_next;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            mask_reg  <= '0;
            blank_reg <= 1'b0;
        end else begin
            mask_reg  <= mask_next;
            blank_reg <= blank_next;
        end
    end

    assign out_blank = blank_reg;
`else
    assign sel_next  = onehot_next;
    assign out_blank = 1'b0;
`endif

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            presc_reg     <= '0;
            idx_reg       <= 3'd0;
            shadow_reg    <= '0;
            pending_reg   <= '0;
            pend_flag_reg <= 1'b0;
            digit_reg     <= 4'd0;
            sel_reg       <= SEL_RST;
            frame_reg     <= 1'b0;
        end else begin
            presc_reg     <= presc_next;
            idx_reg       <= idx_next;
            shadow_reg    <= shadow_next;
            pending_reg   <= pending_next;
            pend_flag_reg <= pend_flag_next;
            digit_reg     <= digit_next;
            sel_reg       <= sel_next ^ SEL_INV;
            frame_reg     <= wrap;
        end
    end

    assign out_digit = digit_reg;
    assign out_sel   = sel_reg;
    assign out_idx   = idx_reg;
    assign out_frame = frame_reg;

endmodule

// File: tb/tb_sevenseg_mux.sv
// -----------------------------------------------------------------------------
// tb_sevenseg_mux
//   Directed bench for sevenseg_mux with NUM_DIGITS=4 and divider 4, so each
//   frame takes 16 cycles. A second instance with active-low select covers
//   the select polarity. Both instances share all inputs.
// -----------------------------------------------------------------------------
module tb_sevenseg_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        upd = 1'b0;
    logic [15:0] val = 16'h0000;

    logic [3:0]  digit, digit_n;
    logic [3:0]  sel, sel_n;
    logic [2:0]  idx, idx_n;
    logic        blank, blank_n;
    logic        frame, frame_n;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sevenseg_mux #(
        .NUM_DIGITS(4), .MAIN_CLK(8), .DIGIT_CLK(2), .SEL_ZERO_IS_ON(0)
    ) dut (
        .in_clk(clk), .in_rst(rst), .in_value(val), .in_update(upd),
        .out_digit(digit), .out_sel(sel), .out_idx(idx),
        .out_blank(blank), .out_frame(frame)
    );

    sevenseg_mux #(
        .NUM_DIGITS(4), .MAIN_CLK(8), .DIGIT_CLK(2), .SEL_ZERO_IS_ON(1)
    ) dut_n (
        .in_clk(clk), .in_rst(rst), .in_value(val), .in_update(upd),
        .out_digit(digit_n), .out_sel(sel_n), .out_idx(idx_n),
        .out_blank(blank_n), .out_frame(frame_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Advance until the frame pulse shows, bounded so a stuck DUT still ends
    task automatic wait_wrap();
        int k;
        k = 0;
        while (frame !== 1'b1 && k < 40) begin
            step(1);
            k++;
        end
        check("wrap_reached", {31'd0, frame}, 32'd1);
    endtask

    // Called on the wrap edge. Checks one full frame of value v, four cycles per digit
    task automatic check_frame(input string tag, input logic [15:0] v);
        logic [3:0] oh;
        logic       exp_blank;
        for (int d = 0; d < 4; d++) begin
            oh = 4'(1 << d);
`ifdef SEVENSEG_MUX_BLANK_EN
            exp_blank = (d > 0) && ((v >> (4*d)) == 16'h0000);
`else
            exp_blank = 1'b0;
`endif
            for (int c = 0; c < 4; c++) begin
                check({tag, "_digit"}, {28'd0, digit}, {28'd0, v[d*4 +: 4]});
                check({tag, "_idx"},   {29'd0, idx},   32'(d));
                check({tag, "_sel"},   {28'd0, sel},   {28'd0, exp_blank ? 4'b0000 : oh});
                check({tag, "_blank"}, {31'd0, blank}, {31'd0, exp_blank});
                check({tag, "_frame"}, {31'd0, frame}, {31'd0, (d == 0 && c == 0)});
                step(1);
            end
        end
    endtask

    initial begin
        int cnt;

        // Reset state, including the active-low instance
        step(2);
        check("rst_sel",     {28'd0, sel},     32'h1);
        check("rst_digit",   {28'd0, digit},   32'h0);
        check("rst_idx",     {29'd0, idx},     32'h0);
        check("rst_blank",   {31'd0, blank},   32'h0);
        check("rst_frame",   {31'd0, frame},   32'h0);
        check("rst_sel_n",   {28'd0, sel_n},   32'he);
        check("rst_digit_n", {28'd0, digit_n}, 32'h0);
        check("rst_idx_n",   {29'd0, idx_n},   32'h0);
        check("rst_blank_n", {31'd0, blank_n}, 32'h0);
        check("rst_frame_n", {31'd0, frame_n}, 32'h0);

        // Plain scanning: the select advances every 4 cycles
        rst = 1'b0;
        check("scan_t0_sel", {28'd0, sel}, 32'h1);
        step(3);
        check("scan_t3_sel", {28'd0, sel}, 32'h1);
        step(1);
        check("scan_t4_sel",   {28'd0, sel},   32'h2);
        check("scan_t4_idx",   {29'd0, idx},   32'h1);
        check("scan_t4_sel_n", {28'd0, sel_n}, 32'hd);
        step(4);
        check("scan_t8_sel", {28'd0, sel}, 32'h4);
        step(4);
        check("scan_t12_sel", {28'd0, sel}, 32'h8);
        step(4);
        check("scan_t16_sel",   {28'd0, sel},   32'h1);
        check("scan_t16_frame", {31'd0, frame}, 32'h1);
        check("scan_t16_digit", {28'd0, digit}, 32'h0);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            if (frame === 1'b1) cnt++;
        end
        check("frame_pulses_per_16", 32'(cnt), 32'd1);   // t=32

        // Mid-frame strobe becomes visible only at the next frame
        step(5);                                         // t=37, idx 1
        val = 16'h12AB;
        upd = 1'b1;
        step(1);
        upd = 1'b0;
        check("midframe_hold_digit", {28'd0, digit}, 32'h0);
        step(9);                                         // t=47, idx 3
        check("midframe_idx3",       {29'd0, idx},   32'h3);
        check("midframe_idx3_digit", {28'd0, digit}, 32'h0);
        step(1);                                         // t=48, wrap
        check_frame("f12ab", 16'h12AB);                  // t=64

        // Two strobes in one frame: the later value wins
        step(2);
        val = 16'h1111;
        upd = 1'b1;
        step(1);
        val = 16'h2222;
        step(1);
        upd = 1'b0;
        wait_wrap();                                     // t=80
        check_frame("f2222", 16'h2222);                  // t=96

        // Strobe sampled on the wrap edge: new value from digit 0 onward
        step(15);                                        // t=111
        val = 16'h3456;
        upd = 1'b1;
        step(1);                                         // t=112, wrap
        upd = 1'b0;
        check("wrapstrobe_frame", {31'd0, frame}, 32'h1);
        check("wrapstrobe_d0",    {28'd0, digit}, 32'h6);
        step(4);
        check("wrapstrobe_d1", {28'd0, digit}, 32'h5);
        step(4);
        check("wrapstrobe_d2", {28'd0, digit}, 32'h4);
        step(4);
        check("wrapstrobe_d3", {28'd0, digit}, 32'h3);    // t=124

        // Reset at idx 2 with a strobe pending
        step(12);                                        // t=136
        check("prereset_idx", {29'd0, idx}, 32'h2);
        val = 16'h9999;
        upd = 1'b1;
        step(1);
        upd = 1'b0;
        rst = 1'b1;
        #1;
        check("async_rst_sel",   {28'd0, sel},   32'h1);
        check("async_rst_digit", {28'd0, digit}, 32'h0);
        check("async_rst_idx",   {29'd0, idx},   32'h0);
        check("async_rst_frame", {31'd0, frame}, 32'h0);
        check("async_rst_sel_n", {28'd0, sel_n}, 32'he);
        step(2);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check("postrst_digit", {28'd0, digit}, 32'h0);
            step(1);
        end                                              // t=32

        // Leading-zero value, then an all-zero value
        val = 16'h0050;
        upd = 1'b1;
        step(1);
        upd = 1'b0;
        wait_wrap();
        check_frame("f0050", 16'h0050);
        val = 16'h0000;
        upd = 1'b1;
        step(1);
        upd = 1'b0;
        wait_wrap();
        check_frame("f0000", 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
